// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Each grant runs IDLE -> EXEC -> RESP; the result is held until the owner accepts it.
module alu_share_arb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_b0,
    input  logic [OPW-1:0]  req_op0,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b1,
    input  logic [OPW-1:0]  req_op1,
    output logic [1:0]      resp_valid,
    input  logic [1:0]      resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_zero,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_control,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ptr;
    logic            r_owner;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [OPW-1:0]  r_op;
    logic [XLEN-1:0] r_result;
    logic            r_zero;

    logic            w_grant_any;
    logic            w_grant_idx;
    logic            w_req_fire;
    logic            w_resp_fire;
    logic [XLEN-1:0] w_sel_a;
    logic [XLEN-1:0] w_sel_b;
    logic [OPW-1:0]  w_sel_op;

    // Pointer's requester wins if valid, otherwise the other one.
    always_comb begin
        w_grant_any = |req_valid;
        w_grant_idx = req_valid[r_ptr] ? r_ptr : ~r_ptr;
        w_req_fire  = (r_state == S_IDLE) && !flush && w_grant_any;
        w_resp_fire = (r_state == S_RESP) && resp_ready[r_owner];
        req_ready   = '0;
        if (w_req_fire && !rst) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_a  = w_grant_idx ? req_a1  : req_a0;
        w_sel_b  = w_grant_idx ? req_b1  : req_b0;
        w_sel_op = w_grant_idx ? req_op1 : req_op0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_fire) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_resp_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        resp_valid  = '0;
        if (r_state == S_EXEC) begin
            alu_a       = r_a;
            alu_b       = r_b;
            alu_control = r_op;
        end
        if (r_state == S_RESP) begin
            resp_valid[r_owner] = 1'b1;
        end
        resp_result = r_result;
        resp_zero   = r_zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_fire) begin
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_op    <= w_sel_op;
                r_owner <= w_grant_idx;
                r_ptr   <= ~w_grant_idx;
            end
            // A flush during EXEC abandons the capture so the previous result stays visible.
            if ((r_state == S_EXEC) && !flush) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized and directed bench for alu_share_arb against a transaction-age reference model.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]  req_op0 = '0, req_op1 = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = '0;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_arb #(.XLEN(32), .OPW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU lives in the environment.
    always_comb begin
        alu_result = alu_ref(alu_a, alu_b, alu_control);
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction tracked by its age in cycles since acceptance.
    int          m_busy, m_age, m_owner, m_ptr;
    logic [31:0] m_a, m_b, m_res, m_shown_res;
    logic [3:0]  m_op;
    logic        m_zero, m_shown_zero;
    bit          m_rst_req = 1'b0;

    always @(negedge clk) begin
        int          g;
        logic [1:0]  e_ready, e_rvalid;
        logic [31:0] e_a, e_b;
        logic [3:0]  e_op;
        if (rst || m_rst_req) begin
            m_busy = 0; m_age = 0; m_owner = 0; m_ptr = 0;
            m_shown_res = '0; m_shown_zero = 1'b0;
            m_rst_req = 1'b0;
        end
        g = (req_valid[m_ptr]) ? m_ptr : 1 - m_ptr;
        e_ready = '0;
        if (!rst && m_busy == 0 && !flush && req_valid != 2'b00) e_ready = 2'(2'b01 << g);
        e_a = '0; e_b = '0; e_op = '0;
        if (m_busy != 0 && m_age == 1) begin e_a = m_a; e_b = m_b; e_op = m_op; end
        e_rvalid = (m_busy != 0 && m_age >= 2) ? 2'(2'b01 << m_owner) : 2'b00;
        check("req_ready", req_ready, e_ready);
        check("resp_valid", resp_valid, e_rvalid);
        check("resp_result", resp_result, m_shown_res);
        check("resp_zero", resp_zero, m_shown_zero);
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
        check("alu_control", alu_control, e_op);
        if (!rst) begin
            if (flush) begin
                m_busy = 0;
            end else if (m_busy == 0) begin
                if (req_valid != 2'b00) begin
                    m_owner = g; m_ptr = 1 - g;
                    m_a  = (g == 1) ? req_a1  : req_a0;
                    m_b  = (g == 1) ? req_b1  : req_b0;
                    m_op = (g == 1) ? req_op1 : req_op0;
                    m_res = alu_ref(m_a, m_b, m_op);
                    m_zero = (m_res == 32'd0);
                    m_busy = 1; m_age = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2; m_shown_res = m_res; m_shown_zero = m_zero;
            end else if (resp_ready[m_owner]) begin
                m_busy = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wait_accept(input int idx, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[idx]) ok = 1'b1;
            @(posedge clk); #1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    int grants[16];
    int ng;

    initial begin
        tick; tick; tick;
        rst = 1'b0;

        // Single ADD
        req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = 4'd0; req_valid = 2'b01;
        @(negedge clk);
        check("add_ready", req_ready, 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("add_exec_no_resp", resp_valid, 32'h0);
        check("add_alu_a", alu_a, 32'd5);
        @(negedge clk);
        check("add_resp_valid", resp_valid, 32'h1);
        check("add_result", resp_result, 32'd12);
        check("add_zero", resp_zero, 32'd0);
        @(posedge clk); #1; resp_ready = 2'b01;
        tick; resp_ready = 2'b00;
        @(negedge clk);
        check("add_done", resp_valid, 32'h0);

        // Contention after fresh reset
        @(posedge clk); #1; rst = 1'b1; tick; tick; rst = 1'b0;
        req_a0 = 32'd9; req_b0 = 32'd9; req_op0 = 4'd1;
        req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_op1 = 4'd8;
        req_valid = 2'b11; resp_ready = 2'b11;
        ng = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && ng < 16) begin grants[ng] = req_ready[1] ? 1 : 0; ng++; end
            check("no_dual_resp", 32'(resp_valid == 2'b11), 32'd0);
            if (resp_valid == 2'b01) begin
                check("sub_result", resp_result, 32'd0);
                check("sub_zero", resp_zero, 32'd1);
            end
            if (resp_valid == 2'b10) begin
                check("slt_result", resp_result, 32'd1);
                check("slt_zero", resp_zero, 32'd0);
            end
        end
        check("contention_count", 32'(ng >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check("contention_order", grants[i], i % 2);
        @(posedge clk); #1; req_valid = 2'b00;
        tick; tick; tick; resp_ready = 2'b00;

        // Back-pressure on requester 1
        req_a1 = 32'h8000_0000; req_b1 = 32'd4; req_op1 = 4'd7; req_valid = 2'b10;
        wait_accept(1, "bp_accept");
        req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 32'h2);
            check("bp_result", resp_result, 32'hF800_0000);
            check("bp_blocked", req_ready, 32'h0);
        end
        @(posedge clk); #1; req_valid = 2'b00; resp_ready = 2'b10;
        tick; resp_ready = 2'b00;
        @(negedge clk);
        check("bp_done", resp_valid, 32'h0);

        // Flush during EXEC
        @(posedge clk); #1;
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 4'd0; req_valid = 2'b01;
        wait_accept(0, "fe_accept");
        req_valid = 2'b00; flush = 1'b1;
        tick; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fe_no_resp", resp_valid, 32'h0);
        end
        @(posedge clk); #1; req_valid = 2'b11;
        @(negedge clk);
        check("fe_ptr_kept", req_ready, 32'h2);
        @(posedge clk); #1; req_valid = 2'b00; resp_ready = 2'b11;
        tick; tick; tick; resp_ready = 2'b00;

        // Flush during RESP
        req_valid = 2'b01;
        wait_accept(0, "fr_accept");
        req_valid = 2'b00;
        @(negedge clk); @(negedge clk);
        check("fr_resp_seen", resp_valid, 32'h1);
        @(posedge clk); #1; flush = 1'b1;
        tick; flush = 1'b0;
        @(negedge clk);
        check("fr_cleared", resp_valid, 32'h0);
        check("fr_result_kept", resp_result, 32'd2);
        @(posedge clk); #1; req_valid = 2'b11;
        @(negedge clk);
        check("fr_ptr_kept", req_ready, 32'h2);
        @(posedge clk); #1; req_valid = 2'b00; resp_ready = 2'b11;
        tick; tick; tick; resp_ready = 2'b00;

        // Async reset while in RESP with pointer at 1
        req_a0 = 32'd3; req_b0 = 32'd4; req_op0 = 4'd2; req_valid = 2'b01;
        wait_accept(0, "rr_accept");
        req_valid = 2'b11;
        @(negedge clk); @(negedge clk);
        check("rr_in_resp", resp_valid, 32'h1);
        @(posedge clk); #2; rst = 1'b1; #1;
        check("rr_req_ready", req_ready, 32'h0);
        check("rr_resp_valid", resp_valid, 32'h0);
        check("rr_result", resp_result, 32'h0);
        check("rr_zero", resp_zero, 32'h0);
        check("rr_alu_a", alu_a, 32'h0);
        check("rr_alu_ctl", alu_control, 32'h0);
        m_rst_req = 1'b1;
        #1; rst = 1'b0;
        @(negedge clk);
        check("rr_grant_ptr0", req_ready, 32'h1);
        @(posedge clk); #1; req_valid = 2'b00; resp_ready = 2'b11;
        tick; tick; tick; resp_ready = 2'b00;

        // Undefined opcode, wrong-owner accept ignored
        req_a0 = 32'd3; req_b0 = 32'd4; req_op0 = 4'hF; req_valid = 2'b01;
        wait_accept(0, "ud_accept");
        req_valid = 2'b00; resp_ready = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ud_valid", resp_valid, 32'h1);
            check("ud_result", resp_result, 32'h0);
            check("ud_zero", resp_zero, 32'h1);
        end
        @(posedge clk); #1; resp_ready = 2'b01;
        tick; resp_ready = 2'b00;
        @(negedge clk);
        check("ud_done", resp_valid, 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            req_valid  = 2'($urandom);
            resp_ready = 2'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            req_a0  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req_b0  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req_a1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req_b1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req_op0 = 4'($urandom_range(0, 15));
            req_op1 = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        req_valid = 2'b00; flush = 1'b0; resp_ready = 2'b11;
        tick; tick; tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
